hwpe_stream_tcdm_order_ctrl: RTL and testbench

Generates the channel permutation `order_o` for the static TCDM reorder stage directly downstream of it, and rotates that permutation by one position after a programmable number of accepted transactions. The reorder stage routes responses using the current order, so a change while responses are in flight would misroute them. This block tracks per-channel outstanding transactions on the memory side and changes the order only when every channel has drained. It asserts `hold_o` while draining so that new requests are masked at the reorder input.

---
 rtl/hwpe_stream_package.sv | 29 ++
 rtl/hwpe_stream_tcdm_outst_cnt.sv | 51 +++++
 rtl/hwpe_stream_tcdm_order_ctrl.sv | 121 ++++++++++++
 tb/tb_hwpe_stream_tcdm_order_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_package.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_package
// Brief    : Shared types and helpers for the TCDM order controller.
// Revision : 1.0 - initial release
// ============================================================================
package hwpe_stream_package;

    // Widest channel vector the popcount helper accepts.
    localparam int unsigned c_MAX_CHAN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        ROTATE = 2'd3
    } order_ctrl_state_t;

    function automatic logic [5:0] popcount(input logic [c_MAX_CHAN-1:0] vec);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_MAX_CHAN; i++) begin
            cnt = cnt + {5'b0, vec[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_tcdm_outst_cnt.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_tcdm_outst_cnt
// Brief    : Per-channel outstanding-transaction counter with range flags.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_stream_tcdm_outst_cnt #(
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    input  logic dec,
    output logic empty_o,
    output logic ovf_o,
    output logic unf_o
);

    localparam int unsigned      c_CW  = $clog2(MAX_OUTST + 1);
    localparam logic [c_CW-1:0]  c_MAX = c_CW'(MAX_OUTST);
    localparam logic [c_CW-1:0]  c_ONE = c_CW'(1);

    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        ovf_o     = 1'b0;
        unf_o     = 1'b0;
        if (inc && !dec) begin
            if (r_cnt == c_MAX) ovf_o = 1'b1;
            else                w_cnt_nxt = r_cnt + c_ONE;
        end else if (dec && !inc) begin
            if (r_cnt == '0) unf_o = 1'b1;
            else             w_cnt_nxt = r_cnt - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_cnt <= '0;
        else if (clear) r_cnt <= '0;
        else            r_cnt <= w_cnt_nxt;
    end

    // Reports drained as of the end of this cycle, so a final r_valid lets the
    // controller leave DRAIN on that same edge.
    assign empty_o = (w_cnt_nxt == '0);

endmodule
`default_nettype wire

// File: rtl/hwpe_stream_tcdm_order_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_tcdm_order_ctrl
// Brief    : Rotating channel permutation with drain-before-rotate handshake.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_stream_tcdm_order_ctrl
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_CHAN   = 4,
    parameter int unsigned MAX_OUTST = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic                               enable_i,
    input  logic [CNT_W-1:0]                   period_i,
    input  logic [NB_CHAN-1:0]                 out_req_i,
    input  logic [NB_CHAN-1:0]                 out_gnt_i,
    input  logic [NB_CHAN-1:0]                 out_r_valid_i,
    output logic [NB_CHAN*$clog2(NB_CHAN)-1:0] order_o,
    output logic                               hold_o,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int unsigned      c_IW       = $clog2(NB_CHAN);
    localparam logic [c_IW-1:0]  c_OFF_LAST = c_IW'(NB_CHAN - 1);
    localparam logic [c_IW-1:0]  c_OFF_ONE  = c_IW'(1);
    localparam logic [c_IW:0]    c_NB       = (c_IW + 1)'(NB_CHAN);

    order_ctrl_state_t r_state, w_state_nxt;
    logic [c_IW-1:0]   r_offset;
    logic [CNT_W-1:0]  r_txn_cnt;
    logic              r_hold;
    logic              r_err;

    logic [NB_CHAN-1:0] w_acc;
    logic [NB_CHAN-1:0] w_empty;
    logic [NB_CHAN-1:0] w_ovf;
    logic [NB_CHAN-1:0] w_unf;
    logic [5:0]         w_pop;
    logic [CNT_W:0]     w_sum;
    logic [CNT_W-1:0]   w_txn_sat;
    logic               w_thresh;

    assign w_acc     = out_req_i & out_gnt_i;
    assign w_pop     = popcount(c_MAX_CHAN'(w_acc));
    assign w_sum     = {1'b0, r_txn_cnt} + (CNT_W + 1)'(w_pop);
    assign w_txn_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    // Unsaturated sum keeps the comparison exact even when the counter pins.
    assign w_thresh  = (period_i != '0) && (w_sum >= {1'b0, period_i});

    for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
        hwpe_stream_tcdm_outst_cnt #(
            .MAX_OUTST (MAX_OUTST)
        ) u_outst_cnt (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .clear   (clear_i),
            .inc     (w_acc[c]),
            .dec     (out_r_valid_i[c]),
            .empty_o (w_empty[c]),
            .ovf_o   (w_ovf[c]),
            .unf_o   (w_unf[c])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable_i) w_state_nxt = RUN;
            RUN: begin
                if (!enable_i)     w_state_nxt = IDLE;
                else if (w_thresh) w_state_nxt = DRAIN;
            end
            DRAIN:   if ((&w_empty) && !(|w_acc)) w_state_nxt = ROTATE;
            ROTATE:  w_state_nxt = enable_i ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_offset  <= '0;
            r_txn_cnt <= '0;
            r_hold    <= 1'b0;
            r_err     <= 1'b0;
        end else if (clear_i) begin
            r_state   <= IDLE;
            r_offset  <= '0;
            r_txn_cnt <= '0;
            r_hold    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= (w_state_nxt == DRAIN) || (w_state_nxt == ROTATE);
            if ((|w_ovf) || (|w_unf)) r_err <= 1'b1;
            if (r_state == RUN)         r_txn_cnt <= w_txn_sat;
            else if (r_state == ROTATE) r_txn_cnt <= '0;
            if (r_state == ROTATE)
                r_offset <= (r_offset == c_OFF_LAST) ? '0 : r_offset + c_OFF_ONE;
        end
    end

    for (genvar i = 0; i < NB_CHAN; i++) begin : g_order
        localparam logic [c_IW:0] c_IDX = (c_IW + 1)'(i);
        logic [c_IW:0] w_idx_sum;
        assign w_idx_sum = c_IDX + {1'b0, r_offset};
        assign order_o[i*c_IW +: c_IW] = (w_idx_sum >= c_NB) ? c_IW'(w_idx_sum - c_NB)
                                                             : w_idx_sum[c_IW-1:0];
    end

    assign hold_o = r_hold;
    assign busy_o = r_hold;
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_tcdm_order_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpe_stream_tcdm_order_ctrl
// Brief    : Directed self-checking bench for the TCDM order controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_tcdm_order_ctrl;

    logic        clk;
    logic        rst_ni;
    logic        clear;
    logic        enable;
    logic [15:0] period;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [7:0]  order;
    logic        hold;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Packed order words: {order[3],order[2],order[1],order[0]}
    localparam logic [7:0] c_ORD0 = 8'hE4;
    localparam logic [7:0] c_ORD1 = 8'h39;
    localparam logic [7:0] c_ORD2 = 8'h4E;
    localparam logic [7:0] c_ORD3 = 8'h93;

    hwpe_stream_tcdm_order_ctrl #(
        .NB_CHAN   (4),
        .MAX_OUTST (8),
        .CNT_W     (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear),
        .enable_i      (enable),
        .period_i      (period),
        .out_req_i     (req),
        .out_gnt_i     (gnt),
        .out_r_valid_i (rv),
        .order_o       (order),
        .hold_o        (hold),
        .busy_o        (busy),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] rq, input logic [3:0] gt, input logic [3:0] rvv);
        req = rq;
        gnt = gt;
        rv  = rvv;
        @(posedge clk);
        #1;
    endtask

    // Two accepts per cycle for 4 cycles, each answered one cycle later.
    task automatic rot_burst(input string tag, input logic [7:0] old_o,
                             input logic [7:0] new_o, input bit drop_en);
        for (int k = 0; k < 6; k++) begin
            if (drop_en && k == 4) enable = 1'b0;
            cyc((k < 4) ? 4'b0011 : 4'b0000, (k < 4) ? 4'b0011 : 4'b0000,
                (k >= 1 && k <= 4) ? 4'b0011 : 4'b0000);
            if (k == 2) chk({tag, "_hold_pre"}, hold, 1'b0);
            if (k == 3) chk({tag, "_hold_rise"}, hold, 1'b1);
            if (k == 4) begin
                chk({tag, "_hold_rot"}, hold, 1'b1);
                chk({tag, "_order_old"}, order, old_o);
            end
            if (k == 5) begin
                chk({tag, "_hold_fall"}, hold, 1'b0);
                chk({tag, "_busy_fall"}, busy, 1'b0);
                chk({tag, "_order_new"}, order, new_o);
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        clear  = 1'b0;
        enable = 1'b1;
        period = 16'd8;
        req    = '0;
        gnt    = '0;
        rv     = '0;
        @(posedge clk);
        #1;
        chk("rst_order", order, c_ORD0);
        chk("rst_hold", hold, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        cyc(4'b0, 4'b0, 4'b0);
        rst_ni = 1'b1;

        // No traffic: RUN forever, order untouched
        for (int k = 0; k < 6; k++) cyc(4'b0, 4'b0, 4'b0);
        chk("idle_run_hold", hold, 1'b0);
        chk("idle_run_order", order, c_ORD0);

        rot_burst("rot1", c_ORD0, c_ORD1, 1'b0);

        // Channel 2 keeps 3 outstanding; its r_valids return at t+5..t+7 (t = k 2)
        for (int k = 0; k < 11; k++) begin
            cyc((k <= 2) ? 4'b0111 : 4'b0000, (k <= 2) ? 4'b0111 : 4'b0000,
                ((k >= 1 && k <= 3) ? 4'b0011 : 4'b0000) |
                ((k >= 7 && k <= 9) ? 4'b0100 : 4'b0000));
            if (k == 1) chk("slow_hold_pre", hold, 1'b0);
            if (k == 2) chk("slow_busy_rise", busy, 1'b1);
            if (k == 8) chk("slow_hold_drain", hold, 1'b1);
            if (k == 9) begin
                chk("slow_hold_rot", hold, 1'b1);
                chk("slow_order_old", order, c_ORD1);
            end
            if (k == 10) begin
                chk("slow_hold_fall", hold, 1'b0);
                chk("slow_order_new", order, c_ORD2);
            end
        end

        rot_burst("rot3", c_ORD2, c_ORD3, 1'b0);

        // Period 0 never rotates, but the count still accumulates
        period = 16'd0;
        for (int k = 0; k < 5; k++)
            cyc((k < 4) ? 4'b1111 : 4'b0000, (k < 4) ? 4'b1111 : 4'b0000,
                (k >= 1) ? 4'b1111 : 4'b0000);
        chk("per0_hold", hold, 1'b0);
        chk("per0_order", order, c_ORD3);
        // Lowering the period takes effect at once; minimum 2-cycle hold, offset wraps
        period = 16'd8;
        cyc(4'b0, 4'b0, 4'b0);
        chk("wrap_hold1", hold, 1'b1);
        cyc(4'b0, 4'b0, 4'b0);
        chk("wrap_hold2", hold, 1'b1);
        chk("wrap_order_old", order, c_ORD3);
        cyc(4'b0, 4'b0, 4'b0);
        chk("wrap_hold_fall", hold, 1'b0);
        chk("wrap_order", order, c_ORD0);

        // Overflow: 9 accepts on channel 0 with no responses
        period = 16'd0;
        for (int k = 0; k < 9; k++) begin
            cyc(4'b0001, 4'b0001, 4'b0000);
            if (k == 7) chk("ovf_err_pre", err, 1'b0);
            if (k == 8) chk("ovf_err_set", err, 1'b1);
        end
        cyc(4'b0, 4'b0, 4'b0);
        chk("ovf_err_sticky", err, 1'b1);
        clear = 1'b1;
        cyc(4'b0, 4'b0, 4'b0);
        clear = 1'b0;
        chk("clr_err", err, 1'b0);
        cyc(4'b0, 4'b0, 4'b1000);
        chk("unf_err_set", err, 1'b1);
        clear = 1'b1;
        cyc(4'b0, 4'b0, 4'b0);
        clear = 1'b0;
        chk("clr_err2", err, 1'b0);
        period = 16'd8;
        cyc(4'b0, 4'b0, 4'b0);

        // Enable dropped mid-DRAIN: rotation completes, then IDLE
        rot_burst("endrain", c_ORD0, c_ORD1, 1'b1);
        for (int k = 0; k < 6; k++)
            cyc((k < 4) ? 4'b0011 : 4'b0000, (k < 4) ? 4'b0011 : 4'b0000,
                (k >= 1 && k <= 4) ? 4'b0011 : 4'b0000);
        chk("idle_nocount_hold", hold, 1'b0);
        chk("idle_order", order, c_ORD1);
        enable = 1'b1;
        cyc(4'b0, 4'b0, 4'b0);

        // Clear in the middle of DRAIN
        for (int k = 0; k < 4; k++)
            cyc(4'b0011, 4'b0011, (k >= 1) ? 4'b0011 : 4'b0000);
        chk("clrdrain_hold", hold, 1'b1);
        clear = 1'b1;
        cyc(4'b0, 4'b0, 4'b0011);
        clear = 1'b0;
        chk("clrdrain_order", order, c_ORD0);
        chk("clrdrain_hold0", hold, 1'b0);
        chk("clrdrain_busy0", busy, 1'b0);
        chk("clrdrain_err0", err, 1'b0);
        cyc(4'b0, 4'b0, 4'b0);
        cyc(4'b0, 4'b0, 4'b0);
        chk("after_clr_hold", hold, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
